// File: rtl/tdm_pkg.sv
// Shared types and constants for the framed 4-slot TDM demultiplexer.
package tdm_pkg;

   typedef enum logic {HUNT, LOCKED} state_t;

   localparam int NUM_LANES      = 4;
   localparam int MISS_W         = 3;
   localparam int DEF_MISS_LIMIT = 2;

   typedef logic [1:0]        slot_t;
   typedef logic [MISS_W-1:0] miss_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: increments mod 4, loads 1 on an accepted slot-0 sample, clears on drop.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_clr,
   input  logic  i_load1,
   input  logic  i_inc,
   output slot_t o_slot
);

   slot_t r_slot;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_slot <= '0;
      else if (i_clr)   r_slot <= '0;
      else if (i_load1) r_slot <= slot_t'(1);
      else if (i_inc)   r_slot <= r_slot + slot_t'(1);
   end

   assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux4.sv
// Framed 4-slot TDM demultiplexer with frame-lock tracking; all outputs registered.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int MISS_LIMIT = DEF_MISS_LIMIT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic       i_din,
   input  logic       i_fs,
   output logic       o_a,
   output logic       o_b,
   output logic       o_c,
   output logic       o_d,
   output logic       o_valid,
   output logic       o_lock,
   output logic       o_err,
   output logic [1:0] o_slot
);

   state_t                 r_state;
   miss_t                  r_miss;
   logic [2:0]             r_shadow;
   logic [NUM_LANES-1:0]   r_lane;
   logic                   r_valid;
   logic                   r_lock;
   logic                   r_err;

   slot_t w_slot;
   miss_t w_miss_nxt;
   logic  w_locked_en;
   logic  w_sync_ok;
   logic  w_frame_err;
   logic  w_drop;
   logic  w_take0;
   logic  w_take_mid;
   logic  w_complete;

   // Per-sample decode; shared by the FSM and the slot counter controls.
   always_comb begin
      w_miss_nxt  = r_miss + miss_t'(1);
      w_locked_en = i_en && (r_state == LOCKED);
      w_sync_ok   = i_en && i_fs && ((r_state == HUNT) || (w_slot == 2'd0));
      w_frame_err = w_locked_en && ((w_slot == 2'd0) ? !i_fs : i_fs);
      w_drop      = w_frame_err && (w_miss_nxt >= miss_t'(MISS_LIMIT));
      w_take0     = w_sync_ok || (w_frame_err && !w_drop);
      w_take_mid  = w_locked_en && !i_fs && ((w_slot == 2'd1) || (w_slot == 2'd2));
      w_complete  = w_locked_en && !i_fs && (w_slot == 2'd3);
   end

   tdm_slot_ctr u_slot_ctr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_drop),
      .i_load1 (w_take0),
      .i_inc   (w_take_mid || w_complete),
      .o_slot  (w_slot)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= HUNT;
         r_miss   <= '0;
         r_shadow <= '0;
         r_lane   <= '0;
         r_valid  <= 1'b0;
         r_lock   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_valid <= w_complete;
         r_err   <= w_frame_err;
         if (w_sync_ok) begin
            r_state <= LOCKED;
            r_lock  <= 1'b1;
            r_miss  <= '0;
         end else if (w_drop) begin
            r_state <= HUNT;
            r_lock  <= 1'b0;
            r_miss  <= '0;
         end else if (w_frame_err) begin
            r_miss  <= w_miss_nxt;
         end
         if (w_take0) r_shadow[0] <= i_din;
         if (w_take_mid) begin
            if (w_slot == 2'd1) r_shadow[1] <= i_din;
            else                r_shadow[2] <= i_din;
         end
         if (w_complete) r_lane <= {i_din, r_shadow};
      end
   end

   assign o_a     = r_lane[0];
   assign o_b     = r_lane[1];
   assign o_c     = r_lane[2];
   assign o_d     = r_lane[3];
   assign o_valid = r_valid;
   assign o_lock  = r_lock;
   assign o_err   = r_err;
   assign o_slot  = w_slot;

endmodule

// File: tb/tb_tdm_demux4.sv
// Table-driven bench for tdm_demux4: per-sample expectations queued and checked after each edge.
module tb_tdm_demux4;

   logic       clk, rst_n, en, din, fs;
   logic       a, b, c, d, valid, lock, err;
   logic [1:0] slot;

   typedef struct {
      logic       en, fs, din;
      logic [3:0] abcd;   // {A,B,C,D}
      logic       valid, lock, err;
      logic [1:0] slot;
   } vec_t;

   vec_t tbl_a[$];
   vec_t tbl_b[$];
   vec_t sb[$];
   int   checks = 0;
   int   failures = 0;

   tdm_demux4 #(.MISS_LIMIT(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_fs(fs),
      .o_a(a), .o_b(b), .o_c(c), .o_d(d),
      .o_valid(valid), .o_lock(lock), .o_err(err), .o_slot(slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic e, input logic f, input logic di,
                               input logic [3:0] o, input logic v, input logic l,
                               input logic er, input logic [1:0] s);
      vec_t r;
      r.en = e; r.fs = f; r.din = di; r.abcd = o;
      r.valid = v; r.lock = l; r.err = er; r.slot = s;
      return r;
   endfunction

   task automatic compare(input string name, input vec_t x);
      logic [3:0] got;
      got = {a, b, c, d};
      checks++;
      if (got !== x.abcd || valid !== x.valid || lock !== x.lock ||
          err !== x.err || slot !== x.slot) begin
         failures++;
         $display("FAIL %s: got abcd=%b valid=%b lock=%b err=%b slot=%0d, want abcd=%b valid=%b lock=%b err=%b slot=%0d",
                  name, got, valid, lock, err, slot, x.abcd, x.valid, x.lock, x.err, x.slot);
      end
   endtask

   // Called at posedge+1: drive one sample, queue its expectation, check after the edge.
   task automatic step(input string tag, input int idx, input vec_t v);
      vec_t x;
      en = v.en; fs = v.fs; din = v.din;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s[%0d]: scoreboard empty", tag, idx);
      end else begin
         x = sb.pop_front();
         compare($sformatf("%s[%0d]", tag, idx), x);
      end
   endtask

   initial begin
      // Lock + frame 1011, then gapped frame 0110 starting while VALID is high
      tbl_a.push_back(mk(1,1,1, 4'b0000,0,1,0,1));
      tbl_a.push_back(mk(1,0,0, 4'b0000,0,1,0,2));
      tbl_a.push_back(mk(1,0,1, 4'b0000,0,1,0,3));
      tbl_a.push_back(mk(1,0,1, 4'b1011,1,1,0,0));
      tbl_a.push_back(mk(1,1,0, 4'b1011,0,1,0,1));
      tbl_a.push_back(mk(0,1,1, 4'b1011,0,1,0,1));
      tbl_a.push_back(mk(0,1,1, 4'b1011,0,1,0,1));
      tbl_a.push_back(mk(1,0,1, 4'b1011,0,1,0,2));
      tbl_a.push_back(mk(0,1,0, 4'b1011,0,1,0,2));
      tbl_a.push_back(mk(0,0,0, 4'b1011,0,1,0,2));
      tbl_a.push_back(mk(1,0,1, 4'b1011,0,1,0,3));
      tbl_a.push_back(mk(0,1,1, 4'b1011,0,1,0,3));
      tbl_a.push_back(mk(0,0,0, 4'b1011,0,1,0,3));
      tbl_a.push_back(mk(1,0,0, 4'b0110,1,1,0,0));
      // Flywheeled frame 1100 completes; second missing sync drops lock
      tbl_a.push_back(mk(1,0,1, 4'b0110,0,1,1,1));
      tbl_a.push_back(mk(1,0,1, 4'b0110,0,1,0,2));
      tbl_a.push_back(mk(1,0,0, 4'b0110,0,1,0,3));
      tbl_a.push_back(mk(1,0,0, 4'b1100,1,1,0,0));
      tbl_a.push_back(mk(1,0,1, 4'b1100,0,0,1,0));
      tbl_a.push_back(mk(0,0,0, 4'b1100,0,0,0,0));
      // Relock, early sync at slot 2 restarts frame 1001
      tbl_a.push_back(mk(1,1,0, 4'b1100,0,1,0,1));
      tbl_a.push_back(mk(1,0,0, 4'b1100,0,1,0,2));
      tbl_a.push_back(mk(1,1,1, 4'b1100,0,1,1,1));
      tbl_a.push_back(mk(1,0,0, 4'b1100,0,1,0,2));
      tbl_a.push_back(mk(1,0,0, 4'b1100,0,1,0,3));
      tbl_a.push_back(mk(1,0,1, 4'b1001,1,1,0,0));
      tbl_a.push_back(mk(1,1,1, 4'b1001,0,1,0,1));
      tbl_a.push_back(mk(1,0,1, 4'b1001,0,1,0,2));

      // After reset: HUNT ignores unsynced samples, then lock, then two early syncs drop it
      for (int i = 0; i < 10; i++)
         tbl_b.push_back(mk(1,0,logic'(i % 2), 4'b0000,0,0,0,0));
      tbl_b.push_back(mk(1,1,1, 4'b0000,0,1,0,1));
      tbl_b.push_back(mk(0,0,0, 4'b0000,0,1,0,1));
      tbl_b.push_back(mk(1,0,0, 4'b0000,0,1,0,2));
      tbl_b.push_back(mk(1,0,0, 4'b0000,0,1,0,3));
      tbl_b.push_back(mk(1,1,1, 4'b0000,0,1,1,1));
      tbl_b.push_back(mk(1,1,1, 4'b0000,0,0,1,0));
      tbl_b.push_back(mk(0,0,0, 4'b0000,0,0,0,0));

      rst_n = 1'b0; en = 1'b0; din = 1'b0; fs = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compare("reset_state", mk(0,0,0, 4'b0000,0,0,0,0));
      rst_n = 1'b1;

      for (int i = 0; i < tbl_a.size(); i++) step("seq_a", i, tbl_a[i]);

      // Mid-frame asynchronous reset at slot 2 with lanes at 1001
      #2;
      rst_n = 1'b0;
      #1;
      compare("async_reset", mk(0,0,0, 4'b0000,0,0,0,0));
      en = 1'b0; fs = 1'b0; din = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < tbl_b.size(); i++) step("seq_b", i, tbl_b[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
